// File: rtl/mod_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mod_addsub_pipe
// Purpose  : Two-stage pipelined modular adder/subtractor for the PE datapath.
//            Each transaction computes c = (a + b) mod q or c = (a - b) mod q.
//            The modulus, operands, mode and tag are sampled together, and a
//            range-error flag travels with the result.
// Ports    : clk_i        - clock, rising edge
//            rst_n_i      - synchronous active-low reset
//            valid_i      - input transaction valid
//            ready_o      - block accepts an input this cycle
//            op_i         - 0 = add, 1 = subtract
//            a_i, b_i     - operands (expected < q)
//            q_i          - modulus (expected >= 2)
//            tag_i        - sideband tag, passed through unchanged
//            valid_o      - result valid
//            ready_i      - downstream accepts the result
//            c_o          - result
//            tag_o        - tag of the result in c_o
//            range_err_o  - a >= q, b >= q or q < 2 for this result
// Revision : 1.0 - initial release
// ============================================================================
module mod_addsub_pipe #(
    parameter int W     = 23,
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             op_i,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic [W-1:0]     q_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [W-1:0]     c_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             range_err_o
);

    localparam logic [W-1:0] c_Q_MIN = W'(2);

    // Stage 1 (operand stage) registers
    logic             r_s1_valid;
    logic [W+1:0]     r_s1_r;
    logic [W-1:0]     r_s1_q;
    logic             r_s1_op;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s1_err;

    // Stage 2 (output stage) registers
    logic             r_s2_valid;
    logic [W-1:0]     r_s2_c;
    logic [TAG_W-1:0] r_s2_tag;
    logic             r_s2_err;

    logic             w_s2_load;
    logic             w_s1_load;
    logic [W+1:0]     w_raw;
    logic             w_err;
    logic             w_r_ge_q;
    logic             w_r_neg;
    logic [W-1:0]     w_r_lo;
    logic [W-1:0]     w_c;

    // Each stage may load when it is empty or when the stage after it is
    // draining in this same cycle, so a full pipe still moves one per cycle.
    assign w_s2_load = !r_s2_valid || ready_i;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign ready_o   = w_s1_load;

    // Two guard bits: one for the carry of a + b, one as the sign of a - b.
    assign w_raw = op_i ? ({2'b00, a_i} - {2'b00, b_i})
                        : ({2'b00, a_i} + {2'b00, b_i});
    assign w_err = (a_i >= q_i) | (b_i >= q_i) | (q_i < c_Q_MIN);

    // Single conditional correction. The comparison uses the full-width raw
    // value, while the correction itself only needs the low W bits because
    // the result is truncated to W bits anyway.
    assign w_r_ge_q = (r_s1_r >= {2'b00, r_s1_q});
    assign w_r_neg  = r_s1_r[W+1];
    assign w_r_lo   = r_s1_r[W-1:0];

    always_comb begin
        w_c = w_r_lo;
        if (r_s1_op) begin
            if (w_r_neg) begin
                w_c = w_r_lo + r_s1_q;
            end
        end else begin
            if (w_r_ge_q) begin
                w_c = w_r_lo - r_s1_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_s1_valid <= 1'b0;
            r_s1_r     <= '0;
            r_s1_q     <= '0;
            r_s1_op    <= 1'b0;
            r_s1_tag   <= '0;
            r_s1_err   <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= valid_i;
            if (valid_i) begin
                r_s1_r   <= w_raw;
                r_s1_q   <= q_i;
                r_s1_op  <= op_i;
                r_s1_tag <= tag_i;
                r_s1_err <= w_err;
            end
        end
    end

    // Result fields only update when a real transaction moves in, so they
    // keep the last result while the pipe is idle or stalled.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_s2_valid <= 1'b0;
            r_s2_c     <= '0;
            r_s2_tag   <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_c   <= w_c;
                r_s2_tag <= r_s1_tag;
                r_s2_err <= r_s1_err;
            end
        end
    end

    assign valid_o     = r_s2_valid;
    assign c_o         = r_s2_c;
    assign tag_o       = r_s2_tag;
    assign range_err_o = r_s2_err;

endmodule
`default_nettype wire

// File: tb/tb_mod_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_addsub_pipe
// Purpose  : Self-checking bench for mod_addsub_pipe. Directed cases for
//            latency, back-to-back throughput, modulus boundaries, stall,
//            range errors and reset, followed by randomized traffic with
//            random backpressure. A scoreboard queue holds expected results;
//            a monitor pops and compares on every output transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_addsub_pipe;

    localparam int W     = 23;
    localparam int TAG_W = 4;
    localparam longint c_MASK = (64'sd1 <<< W) - 1;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             valid_i = 1'b0;
    logic             op      = 1'b0;
    logic [W-1:0]     a       = '0;
    logic [W-1:0]     b       = '0;
    logic [W-1:0]     q       = W'(2);
    logic [TAG_W-1:0] tag     = '0;
    logic             ready_i = 1'b1;
    logic             ready_o;
    logic             valid_o;
    logic [W-1:0]     c;
    logic [TAG_W-1:0] tag_o;
    logic             err;

    mod_addsub_pipe #(.W(W), .TAG_W(TAG_W)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .op_i        (op),
        .a_i         (a),
        .b_i         (b),
        .q_i         (q),
        .tag_i       (tag),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .c_o         (c),
        .tag_o       (tag_o),
        .range_err_o (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint c;
        longint tag;
        longint err;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: true modular arithmetic for in-range inputs; for out-of-range
    // inputs, the single conditional correction applied to the raw sum or
    // difference, truncated to W bits.
    function automatic exp_t model(input bit o, input longint av, input longint bv,
                                   input longint qv, input longint t);
        exp_t   e;
        longint s;
        e.err = ((av >= qv) || (bv >= qv) || (qv < 2)) ? 1 : 0;
        e.tag = t;
        if (e.err == 0) begin
            s = o ? (((av - bv) % qv) + qv) % qv : (av + bv) % qv;
        end else begin
            s = o ? (av - bv) : (av + bv);
            if (o && s < 0) s = s + qv;
            else if (!o && s >= qv) s = s - qv;
            s = s & c_MASK;
        end
        e.c = s;
        return e;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got c=%0d tag=%0d with no transaction outstanding", c, tag_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_c",   longint'(c),     e.c);
                chk("sb_tag", longint'(tag_o), e.tag);
                chk("sb_err", longint'(err),   e.err);
            end
        end
    end

    // Output must hold steady while stalled
    logic             hold_v = 1'b0;
    logic [W-1:0]     hold_c;
    logic [TAG_W-1:0] hold_t;
    logic             hold_e;
    always @(negedge clk) begin
        if (rst_n && hold_v && valid_o) begin
            chk("stall_c",   longint'(c),     longint'(hold_c));
            chk("stall_tag", longint'(tag_o), longint'(hold_t));
            chk("stall_err", longint'(err),   longint'(hold_e));
        end
        hold_v = rst_n && valid_o && !ready_i;
        hold_c = c;
        hold_t = tag_o;
        hold_e = err;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Offer one transaction; returns one time unit after the accepting edge.
    task automatic send(input bit o, input longint av, input longint bv, input longint qv,
                        input longint t, input bit rnd_bp, output int waits);
        op      = o;
        a       = av[W-1:0];
        b       = bv[W-1:0];
        q       = qv[W-1:0];
        tag     = t[TAG_W-1:0];
        valid_i = 1'b1;
        waits   = 0;
        for (int k = 0; k < 200; k++) begin
            if (rnd_bp) ready_i = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (ready_o) begin
                sb.push_back(model(o, av, bv, qv, t));
                step();
                valid_i = 1'b0;
                return;
            end
            waits++;
            step();
        end
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: got no accept in 200 cycles, required accept");
        valid_i = 1'b0;
    endtask

    task automatic drain();
        ready_i = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (sb.size() == 0) break;
            step();
        end
        chk("drain_empty", longint'(sb.size()), 0);
    endtask

    initial begin
        int w;
        int unsigned qq, aa, bb;
        bit rop;
        longint max23;
        max23 = c_MASK;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", longint'(valid_o), 0);
        chk("rst_c",     longint'(c),       0);
        chk("rst_tag",   longint'(tag_o),   0);
        chk("rst_err",   longint'(err),     0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", longint'(ready_o), 1);
        step();

        // 1: add with latency check
        send(1'b0, 20, 13, 40, 1, 1'b0, w);
        @(negedge clk);
        chk("t1_not_yet_valid", longint'(valid_o), 0);
        step();
        @(negedge clk);
        chk("t1_valid", longint'(valid_o), 1);
        chk("t1_c",     longint'(c),       33);
        chk("t1_tag",   longint'(tag_o),   1);
        chk("t1_err",   longint'(err),     0);
        idle(2);

        // 2: back-to-back subtracts
        send(1'b1, 20, 13, 40, 2, 1'b0, w);
        chk("t2_first_wait", longint'(w), 0);
        send(1'b1, 7, 13, 40, 3, 1'b0, w);
        chk("t2_second_wait", longint'(w), 0);
        @(negedge clk);
        chk("t2_v1", longint'(valid_o), 1);
        chk("t2_c1", longint'(c),       7);
        step();
        @(negedge clk);
        chk("t2_v2", longint'(valid_o), 1);
        chk("t2_c2", longint'(c),       34);
        idle(2);

        // 3: large-modulus boundaries
        send(1'b0, 8380416, 8380416, 8380417, 9, 1'b0, w);
        idle(3);
        chk("t3_add_max", longint'(c), 8380415);
        send(1'b1, 0, 8380416, 8380417, 10, 1'b0, w);
        idle(3);
        chk("t3_sub_wrap", longint'(c), 1);
        send(1'b1, 123456, 123456, 8380417, 11, 1'b0, w);
        idle(3);
        chk("t3_sub_equal", longint'(c), 0);
        send(1'b0, 8380000, 417, 8380417, 12, 1'b0, w);
        idle(3);
        chk("t3_add_eq_q", longint'(c), 0);

        // 4: backpressure, two accepted into a full pipe, third waits
        ready_i = 1'b0;
        send(1'b0, 10, 5, 40, 4, 1'b0, w);
        send(1'b1, 3, 9, 40, 5, 1'b0, w);
        op = 1'b0; a = W'(39); b = W'(39); q = W'(40); tag = 4'd6; valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_ready_low", longint'(ready_o), 0);
            chk("t4_c_held",    longint'(c),       15);
            step();
        end
        ready_i = 1'b1;
        @(negedge clk);
        chk("t4_ready_release", longint'(ready_o), 1);
        sb.push_back(model(1'b0, 39, 39, 40, 6));
        step();
        valid_i = 1'b0;
        idle(3);
        chk("t4_last_c", longint'(c), 38);
        drain();

        // 5: range error flagged on one result only
        send(1'b0, 45, 3, 40, 7, 1'b0, w);
        idle(3);
        chk("t5_err_set", longint'(err), 1);
        chk("t5_err_c",   longint'(c),   8);
        send(1'b0, 1, 2, 40, 8, 1'b0, w);
        idle(3);
        chk("t5_err_clear", longint'(err), 0);
        chk("t5_c",         longint'(c),   3);

        // 6: reset with a full stalled pipe
        ready_i = 1'b0;
        send(1'b0, 30, 1, 40, 13, 1'b0, w);
        send(1'b0, 31, 1, 40, 14, 1'b0, w);
        idle(1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sb.delete();
        ready_i = 1'b1;
        @(negedge clk);
        chk("t6_valid", longint'(valid_o), 0);
        chk("t6_c",     longint'(c),       0);
        chk("t6_tag",   longint'(tag_o),   0);
        chk("t6_err",   longint'(err),     0);
        chk("t6_ready", longint'(ready_o), 1);
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            chk("t6_no_stale", longint'(valid_o), 0);
        end
        step();

        // Randomized traffic with random backpressure
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 19) == 0) qq = $urandom_range(0, 1);
            else qq = $urandom_range(2, 32'(max23));
            if ($urandom_range(0, 9) == 0) begin
                aa = $urandom_range(0, 32'(max23));
                bb = $urandom_range(0, 32'(max23));
            end else if (qq >= 2) begin
                aa = $urandom_range(0, qq - 1);
                bb = $urandom_range(0, qq - 1);
            end else begin
                aa = 0;
                bb = 0;
            end
            rop = $urandom_range(0, 1) == 1;
            send(rop, longint'(aa), longint'(bb), longint'(qq), longint'($urandom_range(0, 15)), 1'b1, w);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, required finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
